// File: rtl/pp_accumulator_7x7_pkg.sv
// Shared constants and types for the iterative 7x7 Booth partial-product accumulator.
// PROD_W  : product / accumulator width
// NPP     : number of partial products per set
// PP_W    : width of each incoming partial product
// PP_OFS  : LSB weight of each partial product within the product
// state_e : accumulator FSM states
package pp_acc_pkg;

  localparam int unsigned PROD_W   = 14;
  localparam int unsigned NPP      = 4;
  localparam int unsigned PP_MAX_W = 12;

  localparam int unsigned PP_W   [NPP] = '{11, 12, 12, 10};
  localparam int unsigned PP_OFS [NPP] = '{0, 0, 2, 4};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

endpackage

// File: rtl/pp_accumulator_7x7_if.sv
// Bundle of the two valid/ready handshakes around the accumulator.
// Input side : in_valid, in_ready, pp00..pp03 (one partial-product set)
// Output side: out_valid, out_ready, product (14-bit unsigned product)
// master : producer of partial products / consumer of products
// slave  : the accumulator itself
interface pp_accumulator_7x7_if;
  import pp_acc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [10:0]       pp00;
  logic [11:0]       pp01;
  logic [11:0]       pp02;
  logic [9:0]        pp03;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] product;

  modport master (
    output in_valid, pp00, pp01, pp02, pp03, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, pp00, pp01, pp02, pp03, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/pp_accumulator_7x7_align.sv
// Combinational alignment of one partial product to its Booth weight.
// i_pp   : latched partial product, zero-padded to PP_MAX_W
// i_idx  : which partial product this is (selects width and offset)
// o_term : term zero-extended to PROD_W and shifted to its LSB offset;
//          bits pushed above the product MSB are dropped
module pp_align_7x7
  import pp_acc_pkg::*;
(
  input  logic [PP_MAX_W-1:0] i_pp,
  input  logic [1:0]          i_idx,
  output logic [PROD_W-1:0]   o_term
);

  logic [PROD_W-1:0] w_ext;

  always_comb begin
    w_ext = '0;
    // Keep only the bits that belong to the selected partial product.
    for (int unsigned b = 0; b < PP_MAX_W; b++) begin
      if (b < PP_W[i_idx]) begin
        w_ext[b] = i_pp[b];
      end
    end
    o_term = w_ext << PP_OFS[i_idx];
  end

endmodule

// File: rtl/pp_accumulator_7x7.sv
// Iterative accumulator for the four radix-4 Booth partial products of an
// unsigned 7x7 multiply. Takes one set, adds LANES aligned terms per cycle
// modulo 2^14, then presents the product until the consumer takes it.
// clk, rst : rising-edge clock, synchronous active-high reset
// bus      : slave side of both handshakes (set in, product out)
// LANES    : partial products added per accumulate cycle (1, 2 or 4)
// PROD_W   : product width, must match the 7x7 datapath (14)
module pp_accumulator_7x7 #(
  parameter int unsigned LANES  = 1,
  parameter int unsigned PROD_W = 14
) (
  input logic                clk,
  input logic                rst,
  pp_accumulator_7x7_if.slave bus
);

  localparam int unsigned NPP      = pp_acc_pkg::NPP;
  localparam int unsigned PP_MAX_W = pp_acc_pkg::PP_MAX_W;
  localparam int unsigned NGRP     = NPP / LANES;

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("pp_accumulator_7x7: LANES must be 1, 2 or 4");
  end

  if (PROD_W != pp_acc_pkg::PROD_W) begin : g_bad_width
    $error("pp_accumulator_7x7: PROD_W must be 14");
  end

  pp_acc_pkg::state_e r_state;
  pp_acc_pkg::state_e w_state_d;

  logic [PP_MAX_W-1:0] r_pp [NPP];
  logic [PROD_W-1:0]   r_acc;
  logic [PROD_W-1:0]   r_product;
  logic [1:0]          r_count;

  logic [PROD_W-1:0]   w_term [LANES];
  logic [PROD_W-1:0]   w_sum;
  logic                w_accept;
  logic                w_release;
  logic                w_last;

  // Handshake outputs decode registered state only.
  assign bus.in_ready  = (r_state == pp_acc_pkg::IDLE);
  assign bus.out_valid = (r_state == pp_acc_pkg::DONE);
  assign bus.product   = r_product;

  assign w_accept  = bus.in_valid && (r_state == pp_acc_pkg::IDLE);
  assign w_release = bus.out_ready && (r_state == pp_acc_pkg::DONE);
  assign w_last    = (32'(r_count) == NGRP - 1);

  // Lane l handles term count*LANES + l this cycle.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [1:0] w_idx;
    assign w_idx = 2'(32'(r_count) * LANES + l);

    pp_align_7x7 u_align (
      .i_pp   (r_pp[w_idx]),
      .i_idx  (w_idx),
      .o_term (w_term[l])
    );
  end

  // Adder chain; carry out of bit 13 is dropped, which is exact because the
  // sign-extension constants cancel modulo 2^14.
  always_comb begin
    w_sum = r_acc;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_sum = w_sum + w_term[l];
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      pp_acc_pkg::IDLE:  if (w_accept)  w_state_d = pp_acc_pkg::ACCUM;
      pp_acc_pkg::ACCUM: if (w_last)    w_state_d = pp_acc_pkg::DONE;
      pp_acc_pkg::DONE:  if (w_release) w_state_d = pp_acc_pkg::IDLE;
      default:                          w_state_d = pp_acc_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= pp_acc_pkg::IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
      for (int unsigned i = 0; i < NPP; i++) begin
        r_pp[i] <= '0;
      end
    end else begin
      unique case (r_state)
        pp_acc_pkg::IDLE: begin
          if (w_accept) begin
            r_pp[0] <= {1'b0, bus.pp00};
            r_pp[1] <= bus.pp01;
            r_pp[2] <= bus.pp02;
            r_pp[3] <= {2'b00, bus.pp03};
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        pp_acc_pkg::ACCUM: begin
          r_acc   <= w_sum;
          r_count <= r_count + 2'd1;
          if (w_last) begin
            r_product <= w_sum;
          end
        end
        pp_acc_pkg::DONE: begin
          if (w_release) begin
            r_product <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_accumulator_7x7.sv
module tb_pp_accumulator_7x7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Per-instance stimulus and observed outputs; index k drives the LANES=1<<k instance.
  logic        iv   [3];
  logic        ordy [3];
  logic [10:0] p0   [3];
  logic [11:0] p1   [3];
  logic [11:0] p2   [3];
  logic [9:0]  p3   [3];
  logic        irdy [3];
  logic        ov   [3];
  logic [13:0] prod [3];

  pp_accumulator_7x7_if bus0 ();
  pp_accumulator_7x7_if bus1 ();
  pp_accumulator_7x7_if bus2 ();

  assign bus0.in_valid = iv[0];   assign bus1.in_valid = iv[1];   assign bus2.in_valid = iv[2];
  assign bus0.out_ready = ordy[0]; assign bus1.out_ready = ordy[1]; assign bus2.out_ready = ordy[2];
  assign bus0.pp00 = p0[0]; assign bus1.pp00 = p0[1]; assign bus2.pp00 = p0[2];
  assign bus0.pp01 = p1[0]; assign bus1.pp01 = p1[1]; assign bus2.pp01 = p1[2];
  assign bus0.pp02 = p2[0]; assign bus1.pp02 = p2[1]; assign bus2.pp02 = p2[2];
  assign bus0.pp03 = p3[0]; assign bus1.pp03 = p3[1]; assign bus2.pp03 = p3[2];
  assign irdy[0] = bus0.in_ready;  assign irdy[1] = bus1.in_ready;  assign irdy[2] = bus2.in_ready;
  assign ov[0]   = bus0.out_valid; assign ov[1]   = bus1.out_valid; assign ov[2]   = bus2.out_valid;
  assign prod[0] = bus0.product;   assign prod[1] = bus1.product;   assign prod[2] = bus2.product;

  pp_accumulator_7x7 #(.LANES(1), .PROD_W(14)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pp_accumulator_7x7 #(.LANES(2), .PROD_W(14)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pp_accumulator_7x7 #(.LANES(4), .PROD_W(14)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Product implied by a set: weighted sum of the terms, modulo 2^14.
  function automatic int model(input logic [10:0] a0, input logic [11:0] a1,
                               input logic [11:0] a2, input logic [9:0] a3);
    int s;
    s = int'(a0) + int'(a1) + 4 * int'(a2) + 16 * int'(a3);
    return s % 16384;
  endfunction

  // Radix-4 Booth encoding of unsigned a*b with sign-extension-constant packing.
  task automatic booth(input int a, input int b, output logic [10:0] q0,
                       output logic [11:0] q1, output logic [11:0] q2, output logic [9:0] q3);
    int bx, trip, mag;
    logic neg;
    logic [7:0] g [4];
    logic s [4];
    bx = b << 1;
    for (int i = 0; i < 4; i++) begin
      trip = (bx >> (2 * i)) & 7;
      neg = 1'b0;
      case (trip)
        1, 2:    mag = a;
        3:       mag = 2 * a;
        4:       begin mag = 2 * a; neg = 1'b1; end
        5, 6:    begin mag = a; neg = 1'b1; end
        default: mag = 0;
      endcase
      g[i] = neg ? ~8'(mag) : 8'(mag);
      s[i] = neg;
    end
    q0 = {~s[0], s[0], s[0], g[0]};
    q1 = {1'b1, ~s[1], g[1], 1'b0, s[0]};
    q2 = {1'b1, ~s[2], g[2], 1'b0, s[1]};
    q3 = {g[3], 1'b0, s[2]};
  endtask

  // Scoreboard: expected products in acceptance order, per instance.
  int sb [3][16];
  int wr [3];
  int rd [3];
  int pops [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        rd[k] = wr[k];
      end else begin
        if (ov[k]) begin
          if (rd[k] == wr[k]) begin
            check("unexpected_output", int'(prod[k]), -1);
          end else begin
            check($sformatf("product_k%0d", k), int'(prod[k]), sb[k][rd[k] % 16]);
            check($sformatf("no_ready_in_done_k%0d", k), int'(irdy[k]), 0);
            if (ordy[k]) begin
              rd[k]++;
              pops[k]++;
            end
          end
        end else begin
          check($sformatf("product_zero_k%0d", k), int'(prod[k]), 0);
        end
        if (iv[k] && irdy[k]) begin
          sb[k][wr[k] % 16] = model(p0[k], p1[k], p2[k], p3[k]);
          wr[k]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (!irdy[k] && n < 50) begin
      tick();
      n++;
    end
    if (!irdy[k]) check("ready_timeout", 0, 1);
  endtask

  // One set through instance k with out_ready high; checks latency and release.
  task automatic run_set(input int k, input logic [10:0] a0, input logic [11:0] a1,
                         input logic [11:0] a2, input logic [9:0] a3,
                         input int lat, input int hand);
    int n;
    wait_ready(k);
    p0[k] = a0; p1[k] = a1; p2[k] = a2; p3[k] = a3;
    iv[k] = 1'b1;
    ordy[k] = 1'b1;
    tick();
    iv[k] = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      check("busy_in_ready", int'(irdy[k]), 0);
      if (ov[k]) break;
      n++;
    end
    check($sformatf("latency_k%0d", k), n, lat);
    if (hand >= 0) check("hand_product", int'(prod[k]), hand);
    tick();
    check("release_in_ready", int'(irdy[k]), 1);
    check("release_out_valid", int'(ov[k]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] q0;
    logic [11:0] q1, q2;
    logic [9:0]  q3;
    int bad, a, b, n, j, guard, base;
    int acc_cyc [3];
    int sa [3];
    int sbv [3];

    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1;
      p0[k] = '0; p1[k] = '0; p2[k] = '0; p3[k] = '0;
      wr[k] = 0; rd[k] = 0; pops[k] = 0;
    end

    // Model pins against hand-computed values.
    check("model_zero", model(11'h400, 12'hC00, 12'hC00, 10'h000), 16'h0000);
    check("model_single", model(11'h405, 12'hC00, 12'hC00, 10'h000), 16'h0005);
    check("model_pp3", model(11'h400, 12'hC00, 12'hC00, 10'h1FC), 16'h1FC0);
    check("model_wrap", model(11'h7FF, 12'hFFF, 12'hFFF, 10'h3FF), 16'h17EA);
    booth(1, 2, q0, q1, q2, q3);
    check("booth_pin_pp0", int'(q0), 16'h3FD);
    check("booth_pin_pp1", int'(q1), 16'hC05);
    bad = 0;
    for (int x = 0; x < 128; x++) begin
      for (int y = 0; y < 128; y++) begin
        booth(x, y, q0, q1, q2, q3);
        if (model(q0, q1, q2, q3) != x * y) bad++;
      end
    end
    check("booth_model_all_pairs", bad, 0);

    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("reset_in_ready", int'(irdy[k]), 1);
      check("reset_out_valid", int'(ov[k]), 0);
      check("reset_product", int'(prod[k]), 0);
    end

    run_set(0, 11'h400, 12'hC00, 12'hC00, 10'h000, 4, 16'h0000);
    run_set(0, 11'h405, 12'hC00, 12'hC00, 10'h000, 4, 16'h0005);
    run_set(0, 11'h400, 12'hC00, 12'hC00, 10'h1FC, 4, 16'h1FC0);
    run_set(0, 11'h7FF, 12'hFFF, 12'hFFF, 10'h3FF, 4, 16'h17EA);
    run_set(1, 11'h7FF, 12'hFFF, 12'hFFF, 10'h3FF, 2, 16'h17EA);
    run_set(2, 11'h7FF, 12'hFFF, 12'hFFF, 10'h3FF, 1, 16'h17EA);
    run_set(1, 11'h405, 12'hC00, 12'hC00, 10'h000, 2, 16'h0005);
    run_set(2, 11'h400, 12'hC00, 12'hC00, 10'h1FC, 1, 16'h1FC0);

    // Backpressure in DONE with ignored in_valid pulses.
    wait_ready(0);
    p0[0] = 11'h7FF; p1[0] = 12'hFFF; p2[0] = 12'hFFF; p3[0] = 10'h3FF;
    iv[0] = 1'b1; ordy[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 20) begin
      tick();
      n++;
    end
    check("bp_reached_done", int'(ov[0]), 1);
    for (int i = 0; i < 7; i++) begin
      iv[0] = (i % 2 == 0);
      p0[0] = 11'(i * 37); p3[0] = 10'(i * 5);
      tick();
      check("bp_out_valid", int'(ov[0]), 1);
      check("bp_in_ready", int'(irdy[0]), 0);
      check("bp_product", int'(prod[0]), 16'h17EA);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    tick();
    check("bp_release_in_ready", int'(irdy[0]), 1);
    check("bp_release_out_valid", int'(ov[0]), 0);

    // Reset during the second ACCUM cycle.
    p0[0] = 11'h7FF; p1[0] = 12'hFFF; p2[0] = 12'hFFF; p3[0] = 10'h3FF;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", int'(irdy[0]), 1);
    check("midrst_out_valid", int'(ov[0]), 0);
    check("midrst_product", int'(prod[0]), 0);
    booth(93, 61, q0, q1, q2, q3);
    run_set(0, q0, q1, q2, q3, 4, 93 * 61);

    // Back-to-back with in_valid held high.
    sa[0] = 5;   sbv[0] = 7;
    sa[1] = 127; sbv[1] = 127;
    sa[2] = 100; sbv[2] = 3;
    base = pops[0];
    ordy[0] = 1'b1;
    booth(sa[0], sbv[0], q0, q1, q2, q3);
    p0[0] = q0; p1[0] = q1; p2[0] = q2; p3[0] = q3;
    iv[0] = 1'b1;
    j = 0;
    guard = 0;
    while (j < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (irdy[0]) begin
        acc_cyc[j] = cyc;
        tick();
        j++;
        if (j < 3) begin
          booth(sa[j], sbv[j], q0, q1, q2, q3);
          p0[0] = q0; p1[0] = q1; p2[0] = q2; p3[0] = q3;
        end else begin
          iv[0] = 1'b0;
        end
      end
    end
    check("b2b_accepts", j, 3);
    check("b2b_spacing_1", acc_cyc[1] - acc_cyc[0], 6);
    check("b2b_spacing_2", acc_cyc[2] - acc_cyc[1], 6);
    guard = 0;
    while (pops[0] < base + 3 && guard < 40) begin
      tick();
      guard++;
    end
    check("b2b_products_seen", pops[0] - base, 3);

    // Random operand pairs against A*B.
    for (int i = 0; i < 500; i++) begin
      a = $urandom_range(127);
      b = $urandom_range(127);
      booth(a, b, q0, q1, q2, q3);
      run_set(2, q0, q1, q2, q3, 1, a * b);
    end
    for (int i = 0; i < 150; i++) begin
      a = $urandom_range(127);
      b = $urandom_range(127);
      booth(a, b, q0, q1, q2, q3);
      run_set(1, q0, q1, q2, q3, 2, a * b);
    end
    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(127);
      b = $urandom_range(127);
      booth(a, b, q0, q1, q2, q3);
      run_set(0, q0, q1, q2, q3, 4, a * b);
    end

    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("scoreboard_drained_k%0d", k), wr[k] - rd[k], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pp_accumulator_7x7.md
Name: pp_accumulator_7x7

Overview:
Sequential consumer of the four sign-extended radix-4 Booth partial products for the unsigned 7x7 multiplier. Accepts one partial-product set (pp00..pp03) under a valid/ready handshake. Aligns each term to its Booth weight and accumulates the terms over several cycles. Returns the 14-bit unsigned product under a second valid/ready handshake. Sits between the sign-extension stage and the posit fraction normaliser, where a low-area iterative datapath is preferred over a full compressor tree.

Parameters:
LANES, 1, partial products added per accumulate cycle; legal values 1, 2, 4. Any other value is an elaboration error.
PROD_W, 14, product/accumulator width; fixed at 14 for the 7x7 datapath.

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  partial-product set valid
in_ready  out  1  block can accept a set
pp00  in  11  partial product 0, bits {ns0,s0,s0,gen[7:0]}
pp01  in  12  partial product 1, including the pp0 negate-carry in bit 0
pp02  in  12  partial product 2, including the pp1 negate-carry in bit 0
pp03  in  10  partial product 3, including the pp2 negate-carry in bit 0
out_valid  out  1  product valid
out_ready  in  1  downstream accepts product
product  out  14  unsigned product, modulo 2^14

Behaviour:
- Reset is synchronous and active-high on clk. rst dominates all other inputs, including mid-accumulation: the state goes to IDLE, acc and count clear to 0, in_ready=1, out_valid=0, product=0. Latched partial products are discarded.
- Alignment (LSB offsets): pp00 at bit 0, pp01 at bit 0, pp02 at bit 2, pp03 at bit 4. Each term is zero-extended to 14 bits before shifting. Bits shifted above bit 13 are dropped. All sums are modulo 2^14 and the carry-out is discarded. This is exact because the sign-extension constants cancel modulo 2^14.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - ACCUM: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> ACCUM on in_valid&&in_ready. On that edge, all four inputs are latched, acc<=0 and count<=0.
- ACCUM behaviour:
  - Each cycle adds LANES aligned terms in index order: term index = count*LANES .. count*LANES+LANES-1.
  - count increments by 1 each cycle.
  - On the edge where the last group is added, the state moves to DONE.
  - ACCUM lasts 4/LANES cycles.
- Latency: for an accept at edge E0, out_valid rises after edge E(4/LANES). That is 4, 2 or 1 cycles for LANES = 1, 2, 4.
- DONE: product=acc, held stable while out_valid&&!out_ready, for any duration. On out_valid&&out_ready the block returns to IDLE and out_valid drops on that edge.
- There is no overlap. A new set is accepted only in IDLE, so throughput is one set per (4/LANES + 2) cycles under continuous handshakes.
- in_valid while in_ready=0 is ignored and nothing is latched. Input changes during ACCUM or DONE have no effect on the result.
- product is registered and equals 0 outside DONE.
- No combinational path from any input to in_ready or out_valid.

Decomposition:
- Package pp_acc_pkg holds:
  - constants PROD_W=14 and NPP=4;
  - PP_W[0:3] = {11,12,12,10};
  - PP_OFS[0:3] = {0,0,2,4};
  - a state enum {IDLE, ACCUM, DONE}.
- Sub-module pp_align_7x7: combinational zero-extend-and-shift of one partial product (selected by index) to 14 bits. It is instantiated LANES times, feeding an adder chain into acc.

Test Plan:
- Zero multiplier, LANES=1: pp00=0x400, pp01=0xC00, pp02=0xC00, pp03=0x000 -> product=0x0000. out_valid rises exactly 4 cycles after accept; in_ready=0 for 5 cycles.
- Single term: pp00=0x405, pp01=0xC00, pp02=0xC00, pp03=0x000 -> product=0x0005. pp00=0x400, pp01=0xC00, pp02=0xC00, pp03=0x1FC -> product=0x1FC0.
- Wrap-around: pp00=0x7FF, pp01=0xFFF, pp02=0xFFF, pp03=0x3FF -> product=0x17EA, with the carry-out discarded. Repeat for LANES=2 and LANES=4: same product, out_valid after 2 and 1 cycles respectively.
- Backpressure: hold out_ready=0 for 7 cycles in DONE -> product and out_valid stable, in_ready=0, and in_valid pulses are ignored. Then out_ready=1 -> return to IDLE the next cycle.
- Reset mid-op: assert rst during the second ACCUM cycle -> next cycle IDLE, in_ready=1, out_valid=0, product=0. A fresh set then produces the correct result.
- Back-to-back: in_valid held high with 3 different sets and out_ready=1 -> 3 products in order. Randomised comparison against a golden model of A*B for all 16384 operand pairs through a Booth/sign-extension reference model.
